l1v_yanitlayici: RTL and testbench

//  Responder end of the core's L1 data (l1v) request interface: word-organised data scratchpad.

---
 rtl/l1v_yanitlayici.sv | 120 ++++++++++++
 tb/tb_l1v_yanitlayici.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1v_yanitlayici.sv
// L1 data request responder: a single-outstanding, word-organised scratchpad standing in for the L1 data cache.
// Completes each request after a fixed latency with an address window check, byte-masked stores and flush.
module l1v_yanitlayici #(
   parameter int unsigned BELLEK_SOZCUK = 1024,
   parameter int unsigned GECIKME       = 2,
   parameter logic [31:0] TABAN_ADRES   = 32'h4000_0000
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        bh_bosalt_i,
   input  logic        l1v_istek_i,
   input  logic        l1v_yaz_i,
   input  logic [31:0] l1v_hedef_adres_i,
   input  logic [31:0] l1v_veri_i,
   input  logic [3:0]  l1v_maske_i,
   output logic [31:0] l1v_veri_o,
   output logic        l1v_hazir_o,
   output logic        l1v_hata_o
);
   localparam int unsigned IW        = (BELLEK_SOZCUK > 1) ? $clog2(BELLEK_SOZCUK) : 1;
   localparam logic [32:0] PENCERE   = 33'(4 * BELLEK_SOZCUK);
   localparam logic [3:0]  SAYAC_ILK = 4'(GECIKME - 1);

   typedef enum logic [1:0] {BOSTA, BEKLE, YANIT} durum_t;

   durum_t        durum, durum_sonraki;
   logic [3:0]    sayac, sayac_sonraki;
   logic          kabul;
   logic          yaz_onay;

   logic [32:0]   fark;
   logic          adres_gecerli;
   logic [IW-1:0] sira_q;
   logic          gecerli_q;
   logic          yaz_q;
   logic [31:0]   veri_q;
   logic [3:0]    maske_q;

   logic [31:0]   bellek [BELLEK_SOZCUK];

   // 33-bit subtraction: an address below the base borrows into bit 32 and fails the single compare.
   assign fark          = {1'b0, l1v_hedef_adres_i} - {1'b0, TABAN_ADRES};
   assign adres_gecerli = (fark < PENCERE);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         durum <= BOSTA;
         sayac <= '0;
      end else begin
         durum <= durum_sonraki;
         sayac <= sayac_sonraki;
      end
   end

   always_comb begin
      durum_sonraki = durum;
      sayac_sonraki = sayac;
      kabul         = 1'b0;
      if (bh_bosalt_i) begin
         durum_sonraki = BOSTA;
      end else begin
         unique case (durum)
            BOSTA: begin
               if (l1v_istek_i) begin
                  kabul         = 1'b1;
                  sayac_sonraki = SAYAC_ILK;
                  durum_sonraki = (GECIKME == 1) ? YANIT : BEKLE;
               end
            end
            BEKLE: begin
               sayac_sonraki = sayac - 4'd1;
               if (sayac <= 4'd1) begin
                  durum_sonraki = YANIT;
               end
            end
            YANIT:   durum_sonraki = BOSTA;
            default: durum_sonraki = BOSTA;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sira_q    <= '0;
         gecerli_q <= 1'b0;
         yaz_q     <= 1'b0;
         veri_q    <= '0;
         maske_q   <= '0;
      end else if (kabul) begin
         sira_q    <= fark[IW+1:2];
         gecerli_q <= adres_gecerli;
         yaz_q     <= l1v_yaz_i;
         veri_q    <= l1v_veri_i;
         maske_q   <= l1v_maske_i;
      end
   end

   // A flush landing on the response cycle still cancels the commit.
   assign yaz_onay = (durum == YANIT) && !bh_bosalt_i && yaz_q && gecerli_q;

   always_ff @(posedge clk_i) begin
      if (yaz_onay) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (maske_q[b]) begin
               bellek[sira_q][8*b +: 8] <= veri_q[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      l1v_hazir_o = (durum == YANIT);
      l1v_hata_o  = l1v_hazir_o && !gecerli_q;
      l1v_veri_o  = '0;
      if (l1v_hazir_o && gecerli_q && !yaz_q) begin
         l1v_veri_o = bellek[sira_q];
      end
   end

endmodule

// File: tb/tb_l1v_yanitlayici.sv
// Bench for l1v_yanitlayici: directed scenarios plus randomized traffic against a word-array reference model.
// A second instance with single-cycle latency covers back-to-back acceptance.
module tb_l1v_yanitlayici;
   localparam logic [31:0] TABAN = 32'h4000_0000;
   localparam int          NW    = 1024;

   logic        clk = 1'b0;
   logic        rstn;
   logic        bos, istek, yaz;
   logic [31:0] adr, wd, rd;
   logic [3:0]  msk;
   logic        hazir, hata;

   logic        bos1;
   logic        istek1, yaz1;
   logic [31:0] adr1, wd1, rd1;
   logic [3:0]  msk1;
   logic        hazir1, hata1;

   int errors = 0;
   int checks = 0;

   logic [31:0] ref_mem [NW];

   always #5 clk = ~clk;

   l1v_yanitlayici #(.BELLEK_SOZCUK(NW), .GECIKME(2), .TABAN_ADRES(TABAN)) u_dut (
      .clk_i(clk), .rstn_i(rstn), .bh_bosalt_i(bos), .l1v_istek_i(istek), .l1v_yaz_i(yaz),
      .l1v_hedef_adres_i(adr), .l1v_veri_i(wd), .l1v_maske_i(msk),
      .l1v_veri_o(rd), .l1v_hazir_o(hazir), .l1v_hata_o(hata));

   l1v_yanitlayici #(.BELLEK_SOZCUK(NW), .GECIKME(1), .TABAN_ADRES(TABAN)) u_dut1 (
      .clk_i(clk), .rstn_i(rstn), .bh_bosalt_i(bos1), .l1v_istek_i(istek1), .l1v_yaz_i(yaz1),
      .l1v_hedef_adres_i(adr1), .l1v_veri_i(wd1), .l1v_maske_i(msk1),
      .l1v_veri_o(rd1), .l1v_hazir_o(hazir1), .l1v_hata_o(hata1));

   function automatic bit in_win(input logic [31:0] a);
      longint x;
      x = {32'b0, a};
      return (x >= longint'(TABAN)) && (x < longint'(TABAN) + 4 * NW);
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a - TABAN) >> 2);
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a);
      return in_win(a) ? ref_mem[widx(a)] : 32'h0;
   endfunction

   task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      int i;
      logic [31:0] w;
      if (in_win(a)) begin
         i = widx(a);
         w = ref_mem[i];
         for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
         ref_mem[i] = w;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Drives one request from a BOSTA cycle, scrambles inputs after accept, returns after one idle cycle.
   task automatic do_req(input logic y, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                         input bit drop, output logic [31:0] rv, output logic rh, output int lat,
                         output logic tail);
      yaz = y; adr = a; wd = d; msk = m; istek = 1'b1;
      lat = 99; rv = 'x; rh = 'x;
      for (int n = 1; n <= 20; n++) begin
         cycle();
         if (hazir === 1'b1) begin
            lat = n; rv = rd; rh = hata;
            break;
         end
         if (drop) istek = 1'b0;
         yaz = 1'($urandom); adr = $urandom; wd = $urandom; msk = 4'($urandom);
      end
      istek = 1'b0; yaz = 1'b0;
      cycle();
      tail = hazir;
   endtask

   task automatic test_reset();
      rstn = 1'b0; bos = 1'b0; istek = 1'b0; yaz = 1'b0; adr = '0; wd = '0; msk = '0;
      bos1 = 1'b0; istek1 = 1'b0; yaz1 = 1'b0; adr1 = '0; wd1 = '0; msk1 = '0;
      #2;
      checks++; if (hazir !== 1'b0) begin errors++; $display("FAIL reset_hazir: got %b exp 0", hazir); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_veri: got %h exp 0", rd); end
      checks++; if (hata !== 1'b0) begin errors++; $display("FAIL reset_hata: got %b exp 0", hata); end
      checks++; if (hazir1 !== 1'b0) begin errors++; $display("FAIL reset_hazir1: got %b exp 0", hazir1); end
      cycle(); cycle();
      rstn = 1'b1;
      cycle();
   endtask

   task automatic test_store_load();
      logic [31:0] rv; logic rh, tl; int lat;
      do_req(1'b1, TABAN + 8, 32'hDEADBEEF, 4'b1111, 1'b0, rv, rh, lat, tl);
      model_store(TABAN + 8, 32'hDEADBEEF, 4'b1111);
      checks++; if (lat !== 2) begin errors++; $display("FAIL st_lat: got %0d exp 2", lat); end
      checks++; if (rh !== 1'b0) begin errors++; $display("FAIL st_hata: got %b exp 0", rh); end
      checks++; if (tl !== 1'b0) begin errors++; $display("FAIL st_pulse_width: got %b exp 0", tl); end
      do_req(1'b0, TABAN + 8, 32'h0, 4'b0000, 1'b0, rv, rh, lat, tl);
      checks++; if (lat !== 2) begin errors++; $display("FAIL ld_lat: got %0d exp 2", lat); end
      checks++; if (rv !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_veri: got %h exp deadbeef", rv); end
      checks++; if (rh !== 1'b0) begin errors++; $display("FAIL ld_hata: got %b exp 0", rh); end
   endtask

   task automatic test_partial();
      logic [31:0] rv; logic rh, tl; int lat;
      do_req(1'b1, TABAN + 9, 32'h0000AB00, 4'b0010, 1'b0, rv, rh, lat, tl);
      model_store(TABAN + 9, 32'h0000AB00, 4'b0010);
      do_req(1'b0, TABAN + 8, 32'h0, 4'b0000, 1'b0, rv, rh, lat, tl);
      checks++; if (rv !== model_load(TABAN + 8)) begin errors++; $display("FAIL partial_veri: got %h exp %h", rv, model_load(TABAN + 8)); end
      do_req(1'b1, TABAN + 8, 32'hFFFFFFFF, 4'b0000, 1'b0, rv, rh, lat, tl);
      checks++; if (lat !== 2) begin errors++; $display("FAIL mask0_lat: got %0d exp 2", lat); end
      do_req(1'b0, TABAN + 8, 32'h0, 4'b1111, 1'b0, rv, rh, lat, tl);
      checks++; if (rv !== model_load(TABAN + 8)) begin errors++; $display("FAIL mask0_veri: got %h exp %h", rv, model_load(TABAN + 8)); end
   endtask

   task automatic test_out_of_range();
      logic [31:0] rv; logic rh, tl; int lat;
      logic [31:0] top;
      top = TABAN + 4 * NW;
      do_req(1'b0, 32'h0000_0010, 32'h0, 4'b1111, 1'b0, rv, rh, lat, tl);
      checks++; if (lat !== 2) begin errors++; $display("FAIL oor_ld_lat: got %0d exp 2", lat); end
      checks++; if (rv !== 32'h0) begin errors++; $display("FAIL oor_ld_veri: got %h exp 0", rv); end
      checks++; if (rh !== 1'b1) begin errors++; $display("FAIL oor_ld_hata: got %b exp 1", rh); end
      do_req(1'b1, top - 4, 32'h13572468, 4'b1111, 1'b0, rv, rh, lat, tl);
      model_store(top - 4, 32'h13572468, 4'b1111);
      checks++; if (rh !== 1'b0) begin errors++; $display("FAIL last_word_hata: got %b exp 0", rh); end
      do_req(1'b1, top, 32'hFFFFFFFF, 4'b1111, 1'b0, rv, rh, lat, tl);
      checks++; if (rh !== 1'b1) begin errors++; $display("FAIL oor_st_hata: got %b exp 1", rh); end
      do_req(1'b0, top - 4, 32'h0, 4'b0000, 1'b0, rv, rh, lat, tl);
      checks++; if (rv !== model_load(top - 4)) begin errors++; $display("FAIL oor_st_unchanged: got %h exp %h", rv, model_load(top - 4)); end
      do_req(1'b0, TABAN - 4, 32'h0, 4'b0000, 1'b0, rv, rh, lat, tl);
      checks++; if (rh !== 1'b1) begin errors++; $display("FAIL below_base_hata: got %b exp 1", rh); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rv; logic rh, tl; int lat;
      logic [31:0] exp_old;
      do_req(1'b1, TABAN, 32'hAAAA0001, 4'b1111, 1'b0, rv, rh, lat, tl);
      model_store(TABAN, 32'hAAAA0001, 4'b1111);
      exp_old = model_load(TABAN);
      istek = 1'b1; yaz = 1'b0; adr = TABAN; msk = 4'b1111; wd = '0;
      for (int c = 0; c <= 6; c++) begin
         if (c > 0) cycle();
         checks++;
         if (hazir !== ((c == 2) || (c == 5))) begin
            errors++; $display("FAIL b2b_hazir_c%0d: got %b exp %b", c, hazir, (c == 2) || (c == 5));
         end
         if (c == 2) begin
            checks++; if (rd !== exp_old) begin errors++; $display("FAIL b2b_ld_veri: got %h exp %h", rd, exp_old); end
            yaz = 1'b1; wd = 32'h5;
         end
         if (c == 5) begin
            istek = 1'b0;
            model_store(TABAN, 32'h5, 4'b1111);
         end
      end
      do_req(1'b0, TABAN, 32'h0, 4'b0000, 1'b0, rv, rh, lat, tl);
      checks++; if (rv !== model_load(TABAN)) begin errors++; $display("FAIL b2b_reload: got %h exp %h", rv, model_load(TABAN)); end
   endtask

   task automatic test_flush();
      logic [31:0] rv; logic rh, tl; int lat;
      logic seen;
      do_req(1'b1, TABAN + 16, 32'h11111111, 4'b1111, 1'b0, rv, rh, lat, tl);
      model_store(TABAN + 16, 32'h11111111, 4'b1111);
      // flush in the cycle after accept
      istek = 1'b1; yaz = 1'b1; adr = TABAN + 16; wd = 32'hCAFEF00D; msk = 4'b1111;
      cycle();
      istek = 1'b0; bos = 1'b1;
      cycle();
      bos = 1'b0;
      checks++; if (hazir !== 1'b0) begin errors++; $display("FAIL flush_bekle_hazir: got %b exp 0", hazir); end
      do_req(1'b0, TABAN + 16, 32'h0, 4'b0000, 1'b0, rv, rh, lat, tl);
      checks++; if (lat !== 2) begin errors++; $display("FAIL flush_next_lat: got %0d exp 2", lat); end
      checks++; if (rv !== model_load(TABAN + 16)) begin errors++; $display("FAIL flush_bekle_veri: got %h exp %h", rv, model_load(TABAN + 16)); end
      // flush together with a request in BOSTA
      istek = 1'b1; yaz = 1'b1; wd = 32'h22222222; bos = 1'b1;
      cycle();
      istek = 1'b0; bos = 1'b0; seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (hazir === 1'b1) seen = 1'b1;
         cycle();
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_bosta_hazir: got %b exp 0", seen); end
      // flush in the response cycle
      istek = 1'b1; yaz = 1'b1; adr = TABAN + 16; wd = 32'h33333333; msk = 4'b1111;
      cycle();
      cycle();
      checks++; if (hazir !== 1'b1) begin errors++; $display("FAIL flush_yanit_visible: got %b exp 1", hazir); end
      istek = 1'b0; bos = 1'b1;
      cycle();
      bos = 1'b0;
      checks++; if (hazir !== 1'b0) begin errors++; $display("FAIL flush_yanit_drop: got %b exp 0", hazir); end
      do_req(1'b0, TABAN + 16, 32'h0, 4'b0000, 1'b0, rv, rh, lat, tl);
      checks++; if (rv !== model_load(TABAN + 16)) begin errors++; $display("FAIL flush_yanit_veri: got %h exp %h", rv, model_load(TABAN + 16)); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rv; logic rh, tl; int lat;
      do_req(1'b1, TABAN + 20, 32'hA5A5A5A5, 4'b1111, 1'b0, rv, rh, lat, tl);
      model_store(TABAN + 20, 32'hA5A5A5A5, 4'b1111);
      istek = 1'b1; yaz = 1'b1; adr = TABAN + 20; wd = 32'h5A5A5A5A; msk = 4'b1111;
      cycle();
      istek = 1'b0; rstn = 1'b0;
      #1;
      checks++; if ({hazir, hata, rd} !== 34'h0) begin errors++; $display("FAIL rst_bekle_out: got %b%b%h exp 0", hazir, hata, rd); end
      cycle();
      rstn = 1'b1;
      cycle();
      istek = 1'b1; yaz = 1'b0;
      cycle();
      cycle();
      checks++; if (hazir !== 1'b1 || rd !== model_load(TABAN + 20)) begin
         errors++; $display("FAIL rst_nocommit: got %b/%h exp 1/%h", hazir, rd, model_load(TABAN + 20));
      end
      istek = 1'b0; rstn = 1'b0;
      #1;
      checks++; if ({hazir, hata, rd} !== 34'h0) begin errors++; $display("FAIL rst_yanit_out: got %b%b%h exp 0", hazir, hata, rd); end
      cycle();
      rstn = 1'b1;
      cycle();
   endtask

   task automatic test_gecikme1();
      istek1 = 1'b1; yaz1 = 1'b1; adr1 = TABAN; wd1 = 32'h12345678; msk1 = 4'b1111;
      for (int c = 1; c <= 7; c++) begin
         cycle();
         checks++;
         if (hazir1 !== 1'(c % 2)) begin errors++; $display("FAIL g1_hazir_c%0d: got %b exp %b", c, hazir1, 1'(c % 2)); end
         if (c == 1) yaz1 = 1'b0;
         if (c >= 3 && (c % 2) == 1) begin
            checks++;
            if (rd1 !== 32'h12345678 || hata1 !== 1'b0) begin
               errors++; $display("FAIL g1_veri_c%0d: got %h/%b exp 12345678/0", c, rd1, hata1);
            end
         end
      end
      istek1 = 1'b0;
      cycle();
   endtask

   task automatic test_random();
      logic [31:0] rv; logic rh, tl; int lat;
      logic [31:0] a, d; logic [3:0] m; logic y;
      for (int i = 0; i < 16; i++) begin
         d = $urandom;
         do_req(1'b1, TABAN + 4 * i, d, 4'b1111, 1'b0, rv, rh, lat, tl);
         model_store(TABAN + 4 * i, d, 4'b1111);
      end
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 19))
            0:       a = TABAN - 1 - $urandom_range(0, 255);
            1:       a = TABAN + 4 * NW + $urandom_range(0, 255);
            2:       a = $urandom_range(0, 65535);
            default: a = TABAN + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
         endcase
         y = 1'($urandom); d = $urandom; m = 4'($urandom);
         do_req(y, a, d, m, $urandom_range(0, 3) == 0, rv, rh, lat, tl);
         checks++;
         if (lat !== 2 || rh !== !in_win(a) || tl !== 1'b0) begin
            errors++; $display("FAIL rnd%0d_ctl: got lat=%0d hata=%b tail=%b exp lat=2 hata=%b tail=0", i, lat, rh, tl, !in_win(a));
         end
         if (!y) begin
            checks++;
            if (rv !== model_load(a)) begin errors++; $display("FAIL rnd%0d_veri: addr %h got %h exp %h", i, a, rv, model_load(a)); end
         end else begin
            model_store(a, d, m);
         end
      end
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_partial();
      test_out_of_range();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_gecikme1();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
